// File: rtl/uart_time_pkg.sv
// Shared constants and types for the UART time/alarm command receiver.
package uart_time_pkg;

   localparam logic [7:0] ASCII_T     = 8'h54;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;

   typedef enum logic [2:0] {
      P_IDLE,
      P_H1,
      P_H0,
      P_COLON,
      P_M1,
      P_M0,
      P_TERM
   } parse_state_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   typedef enum logic {
      MODE_TIME,
      MODE_ALARM
   } mode_t;

   // acc*10 + (ch - '0') using shifts only; callers guarantee the result fits in 7 bits
   function automatic logic [6:0] mul10_add(input logic [6:0] acc, input logic [7:0] ch);
      return 7'({acc, 3'b000} + {2'b00, acc, 1'b0} + {2'b00, ch} - {2'b00, ASCII_0});
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizes the line, finds the start bit and samples mid-bit.
module uart_rx_byte
   import uart_time_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic       byte_err,
   output logic [7:0] data
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_s1, rx_s2, rx_prev;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // A falling edge is required to arm, so a line held low after a bad stop bit does not retrigger
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!rx_s2 && rx_prev) state_d = START;
         end
         START: begin
            if (baud_q == HALF_M1) begin
               baud_d  = '0;
               state_d = rx_s2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (baud_q == FULL_M1) begin
               baud_d  = '0;
               shift_d = {rx_s2, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (baud_q == FULL_M1) begin
               baud_d  = '0;
               state_d = IDLE;
               if (rx_s2) valid_d = 1'b1;
               else       err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign byte_valid = valid_q;
   assign byte_err   = err_q;
   assign data       = shift_q;

endmodule

// File: rtl/uart_time_set_rx.sv
// Parses "Thh:mm"/"Ahh:mm" + CR/LF commands from the UART into time/alarm load pulses.
module uart_time_set_rx
   import uart_time_pkg::*;
#(
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUD        = 115200,
   parameter int MAX_MINUTES = 60,
   parameter int MAX_HOURS   = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           uart_rx,
   output logic                           set_time,
   output logic                           set_alarm,
   output logic [$clog2(MAX_MINUTES):0]   minutes_settings,
   output logic [$clog2(MAX_HOURS):0]     hours_settings,
   output logic                           frame_error,
   output logic                           rx_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int MIN_W = $clog2(MAX_MINUTES) + 1;
   localparam int HR_W  = $clog2(MAX_HOURS) + 1;
   localparam logic [6:0] MAX_MIN7 = 7'(MAX_MINUTES);
   localparam logic [6:0] MAX_HR7  = 7'(MAX_HOURS);

   logic       byte_valid, byte_err;
   logic [7:0] rx_data;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (uart_rx),
      .byte_valid (byte_valid),
      .byte_err   (byte_err),
      .data       (rx_data)
   );

   parse_state_t     state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [6:0]       hours_acc, hours_acc_d;
   logic [6:0]       mins_acc, mins_acc_d;
   logic             set_time_d, set_alarm_d, frame_error_d;
   logic [MIN_W-1:0] minutes_d;
   logic [HR_W-1:0]  hours_d;
   logic             is_digit, is_mode, is_term, bad;

   assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
   assign is_mode  = (rx_data == ASCII_T) || (rx_data == ASCII_A);
   assign is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
   assign rx_busy  = (state_q != P_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= P_IDLE;
         mode_q           <= MODE_TIME;
         hours_acc        <= '0;
         mins_acc         <= '0;
         set_time         <= 1'b0;
         set_alarm        <= 1'b0;
         frame_error      <= 1'b0;
         minutes_settings <= '0;
         hours_settings   <= '0;
      end else begin
         state_q          <= state_d;
         mode_q           <= mode_d;
         hours_acc        <= hours_acc_d;
         mins_acc         <= mins_acc_d;
         set_time         <= set_time_d;
         set_alarm        <= set_alarm_d;
         frame_error      <= frame_error_d;
         minutes_settings <= minutes_d;
         hours_settings   <= hours_d;
      end
   end

   // A stray 'T'/'A' mid-frame is treated as the start of a fresh command rather than an error
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      hours_acc_d   = hours_acc;
      mins_acc_d    = mins_acc;
      set_time_d    = 1'b0;
      set_alarm_d   = 1'b0;
      frame_error_d = 1'b0;
      minutes_d     = minutes_settings;
      hours_d       = hours_settings;
      bad           = 1'b0;
      if (byte_err) begin
         state_d       = P_IDLE;
         frame_error_d = 1'b1;
      end else if (byte_valid) begin
         case (state_q)
            P_IDLE: begin
               if (is_mode) begin
                  mode_d  = (rx_data == ASCII_T) ? MODE_TIME : MODE_ALARM;
                  state_d = P_H1;
               end
            end
            P_H1: begin
               if (is_digit) begin
                  hours_acc_d = mul10_add(7'd0, rx_data);
                  state_d     = P_H0;
               end else bad = 1'b1;
            end
            P_H0: begin
               if (is_digit) begin
                  hours_acc_d = mul10_add(hours_acc, rx_data);
                  state_d     = P_COLON;
               end else bad = 1'b1;
            end
            P_COLON: begin
               if (rx_data == ASCII_COLON) state_d = P_M1;
               else bad = 1'b1;
            end
            P_M1: begin
               if (is_digit) begin
                  mins_acc_d = mul10_add(7'd0, rx_data);
                  state_d    = P_M0;
               end else bad = 1'b1;
            end
            P_M0: begin
               if (is_digit) begin
                  mins_acc_d = mul10_add(mins_acc, rx_data);
                  state_d    = P_TERM;
               end else bad = 1'b1;
            end
            P_TERM: begin
               if (is_term) begin
                  state_d = P_IDLE;
                  if ((hours_acc < MAX_HR7) && (mins_acc < MAX_MIN7)) begin
                     set_time_d  = (mode_q == MODE_TIME);
                     set_alarm_d = (mode_q == MODE_ALARM);
                     minutes_d   = mins_acc[MIN_W-1:0];
                     hours_d     = hours_acc[HR_W-1:0];
                  end else begin
                     frame_error_d = 1'b1;
                  end
               end else bad = 1'b1;
            end
            default: state_d = P_IDLE;
         endcase
         if (bad) begin
            if (is_mode) begin
               mode_d  = (rx_data == ASCII_T) ? MODE_TIME : MODE_ALARM;
               state_d = P_H1;
            end else begin
               state_d       = P_IDLE;
               frame_error_d = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_time_set_rx.sv
// Self-checking bench for uart_time_set_rx: directed command strings plus random frames
// compared cycle by cycle against a frame-level reference model.
module tb_uart_time_set_rx;

   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int BIT_CLKS = CLK_FREQ / BAUD;
   localparam int K_TIME   = 1;
   localparam int K_ALARM  = 2;
   localparam int K_ERR    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       uart_rx = 1'b1;
   logic       set_time, set_alarm, frame_error, rx_busy;
   logic [6:0] minutes_settings;
   logic [5:0] hours_settings;

   uart_time_set_rx #(
      .CLK_FREQ    (CLK_FREQ),
      .BAUD        (BAUD),
      .MAX_MINUTES (60),
      .MAX_HOURS   (24)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .uart_rx          (uart_rx),
      .set_time         (set_time),
      .set_alarm        (set_alarm),
      .minutes_settings (minutes_settings),
      .hours_settings   (hours_settings),
      .frame_error      (frame_error),
      .rx_busy          (rx_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     kind;
      int     hours;
      int     minutes;
      longint lo;
      longint hi;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] frame[$];
   longint     cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   int         held_h = 0;
   int         held_m = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
   endtask

   function automatic bit is_digit(input logic [7:0] b);
      return (b >= "0") && (b <= "9");
   endfunction

   // Reference model: buffer a whole command, decide its fate when it completes or breaks
   task automatic model_byte(input logic [7:0] b, input bit stop_ok, input longint k);
      ev_t e;
      int  pos;
      bit  ok;
      e.kind = 0; e.hours = 0; e.minutes = 0;
      e.lo = k + 96; e.hi = k + 102;
      if (!stop_ok) begin
         e.kind = K_ERR;
         exp_q.push_back(e);
         frame.delete();
         return;
      end
      if (frame.size() == 0) begin
         if (b == "T" || b == "A") frame.push_back(b);
         return;
      end
      pos = frame.size();
      case (pos)
         1, 2, 4, 5: ok = is_digit(b);
         3:          ok = (b == ":");
         default:    ok = (b == 8'h0D) || (b == 8'h0A);
      endcase
      if (ok && pos == 6) begin
         e.hours   = (int'(frame[1]) - 48) * 10 + (int'(frame[2]) - 48);
         e.minutes = (int'(frame[4]) - 48) * 10 + (int'(frame[5]) - 48);
         if (e.hours < 24 && e.minutes < 60) e.kind = (frame[0] == "T") ? K_TIME : K_ALARM;
         else e.kind = K_ERR;
         exp_q.push_back(e);
         frame.delete();
      end else if (ok) begin
         frame.push_back(b);
      end else if (b == "T" || b == "A") begin
         frame.delete();
         frame.push_back(b);
      end else begin
         e.kind = K_ERR;
         exp_q.push_back(e);
         frame.delete();
      end
   endtask

   // Single compare process: pulses must match the next expected event inside its timing window
   always @(negedge clk) begin : compare
      ev_t e;
      int  npulse;
      int  kind;
      if (!rst) begin
         check("reset_outputs",
               int'({set_time, set_alarm, frame_error, rx_busy, minutes_settings, hours_settings}), 0);
         held_h = 0;
         held_m = 0;
      end else begin
         while (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
            e = exp_q.pop_front();
            check("missing_pulse_kind", 0, e.kind);
         end
         npulse = int'(set_time) + int'(set_alarm) + int'(frame_error);
         kind   = set_time ? K_TIME : (set_alarm ? K_ALARM : K_ERR);
         if (npulse > 1) begin
            check("pulse_exclusive", npulse, 1);
         end else if (npulse == 1) begin
            if (exp_q.size() > 0 && cyc >= exp_q[0].lo) begin
               e = exp_q.pop_front();
               check("pulse_kind", kind, e.kind);
               if (e.kind != K_ERR) begin
                  held_h = e.hours;
                  held_m = e.minutes;
               end
            end else begin
               check("unexpected_pulse_kind", kind, 0);
            end
         end
         check("hours_settings", int'(hours_settings), held_h);
         check("minutes_settings", int'(minutes_settings), held_m);
      end
   end

   task automatic idle(input int n);
      uart_rx = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      logic [9:0] bits;
      bits = {stop_ok, b, 1'b0};
      model_byte(b, stop_ok, cyc);
      for (int i = 0; i < 10; i++) begin
         uart_rx = bits[i];
         repeat (BIT_CLKS) begin @(posedge clk); #1; end
      end
      uart_rx = 1'b1;
      check("rx_busy", int'(rx_busy), int'(frame.size() != 0));
      if (!stop_ok) idle(20);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic check_output(input string name, input int h, input int m);
      check({name, "_hours"}, int'(hours_settings), h);
      check({name, "_minutes"}, int'(minutes_settings), m);
   endtask

   task automatic apply_stimulus();
      logic [7:0] frm [7];
      int r, hh, mm, bad_j;
      for (int it = 0; it < 40; it++) begin
         r  = int'($urandom_range(0, 9));
         hh = int'($urandom_range(0, 23));
         mm = int'($urandom_range(0, 59));
         if (r == 0) hh = int'($urandom_range(24, 99));
         if (r == 1) mm = int'($urandom_range(60, 99));
         frm[0] = ($urandom_range(0, 1) == 0) ? 8'h54 : 8'h41;
         frm[1] = 8'(48 + hh / 10);
         frm[2] = 8'(48 + hh % 10);
         frm[3] = 8'h3A;
         frm[4] = 8'(48 + mm / 10);
         frm[5] = 8'(48 + mm % 10);
         frm[6] = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
         if (r == 2) frm[$urandom_range(1, 6)] = 8'($urandom_range(0, 255));
         if (r == 3) send_byte(8'($urandom_range(0, 255)), 1'b1);
         bad_j = (r == 4) ? int'($urandom_range(0, 6)) : -1;
         for (int j = 0; j < 7; j++) send_byte(frm[j], j != bad_j);
         if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 40)));
      end
   endtask

   initial begin
      rst = 1'b0;
      uart_rx = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      idle(20);

      // reset in the middle of a partial frame and mid-byte
      send_str("T1");
      uart_rx = 1'b0;
      repeat (25) begin @(posedge clk); #1; end
      rst = 1'b0;
      uart_rx = 1'b1;
      frame.delete();
      exp_q.delete();
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      idle(30);
      check_output("after_reset", 0, 0);
      send_str("T12:34\r");   idle(30); check_output("t1234", 12, 34);

      send_str("T07:45\r");   idle(30); check_output("t0745", 7, 45);
      send_str("A23:59\n");   idle(30); check_output("a2359", 23, 59);
      send_str("T24:00\r");   idle(30); check_output("t2400_range", 23, 59);
      send_str("T1x:00\r");   idle(30); check_output("t1x_syntax", 23, 59);
      send_str("T00:00\r");   idle(30); check_output("t0000", 0, 0);
      send_str("T12T08:15\r"); idle(30); check_output("restart", 8, 15);

      send_str("T1");
      send_byte("5", 1'b0);
      check("busy_after_stop_err", int'(rx_busy), 0);
      idle(30);

      // a short low glitch mid-frame must not produce a byte
      send_str("T0");
      uart_rx = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      idle(30);
      send_str("1:02\r");     idle(30); check_output("glitch", 1, 2);

      send_str("T01:02\rA03:04\r"); idle(30); check_output("back_to_back", 3, 4);

      apply_stimulus();
      idle(200);
      check("pending_events", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
